// File: rtl/context_switch_controller_pkg.sv
// Shared types and defaults for the context switch controller: FSM encodings,
// OS address defaults and the process-table entry layout.
package context_switch_controller_pkg;

    localparam int unsigned N_PROC_DEFAULT     = 8;
    localparam logic [31:0] OS_LIMIT_DEFAULT   = 32'd300;
    localparam logic [31:0] OS_IDLE_PC_DEFAULT = 32'd0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SAVE   = 3'd1;
    localparam state_t ST_RETIRE = 3'd2;
    localparam state_t ST_SELECT = 3'd3;
    localparam state_t ST_LOAD   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } proc_entry_t;

    function automatic int unsigned pid_width(input int unsigned n_proc);
        return $clog2(n_proc);
    endfunction

endpackage

// File: rtl/context_switch_controller_rr_arbiter.sv
// Rotate-priority pick: first set bit of valid scanning start, start+1, ...
// wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] start,
    output logic [W-1:0] grant,
    output logic         found
);

    logic [W-1:0] idx;

    // Walk from the farthest offset down so the nearest valid slot wins last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = N; i > 0; i--) begin
            idx = start + W'(i - 1);
            if (valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/context_switch_controller.sv
// Process-slot table and switch FSM: saves the interrupted PC, picks the next
// ready slot round robin and issues a one-cycle PC load to fetch.
module context_switch_controller
    import context_switch_controller_pkg::*;
#(
    parameter int unsigned N_PROC     = N_PROC_DEFAULT,
    parameter int unsigned PID_W      = pid_width(N_PROC),
    parameter logic [31:0] OS_LIMIT   = OS_LIMIT_DEFAULT,
    parameter logic [31:0] OS_IDLE_PC = OS_IDLE_PC_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             troca_contexto,
    input  logic [31:0]      pc_processo_trocado,
    input  logic             fim_processo,
    input  logic             create_valid,
    input  logic [PID_W-1:0] create_pid,
    input  logic [31:0]      create_pc,
    output logic             create_err,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic [PID_W-1:0] processo_atual,
    output logic             running,
    output logic             busy,
    output logic             switch_done
);

    state_t           state_q, state_d;
    proc_entry_t      table_q [N_PROC];
    proc_entry_t      table_d [N_PROC];
    logic [31:0]      saved_pc_q, saved_pc_d;
    logic             troca_prev_q, troca_prev_d;
    logic             halt_scan_q, halt_scan_d;
    logic             pc_load_q, pc_load_d;
    logic             switch_done_q, switch_done_d;
    logic             create_err_q, create_err_d;
    logic             running_q, running_d;
    logic [31:0]      pc_next_q, pc_next_d;
    logic [PID_W-1:0] proc_q, proc_d;

    logic             req;
    logic [N_PROC-1:0] valid_vec;
    logic             valid_any;
    logic [PID_W-1:0] scan_start;
    logic [PID_W-1:0] grant;
    logic             found;

    assign req       = troca_contexto & ~troca_prev_q;
    assign valid_any = |valid_vec;
    // Leaving HALT scans from slot 0, i.e. as if the current slot were the last.
    assign scan_start = (halt_scan_q ? {PID_W{1'b1}} : proc_q) + PID_W'(1);

    always_comb begin
        for (int unsigned i = 0; i < N_PROC; i++) begin
            valid_vec[i] = table_q[i].valid;
        end
    end

    rr_arbiter #(
        .N (N_PROC),
        .W (PID_W)
    ) u_rr_arbiter (
        .valid (valid_vec),
        .start (scan_start),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        saved_pc_d    = saved_pc_q;
        troca_prev_d  = troca_contexto;
        halt_scan_d   = halt_scan_q;
        pc_load_d     = 1'b0;
        switch_done_d = 1'b0;
        create_err_d  = 1'b0;
        running_d     = running_q;
        pc_next_d     = pc_next_q;
        proc_d        = proc_q;

        case (state_q)
            ST_IDLE: begin
                if (fim_processo) begin
                    state_d = ST_RETIRE;
                end else if (req) begin
                    saved_pc_d = pc_processo_trocado;
                    state_d    = ST_SAVE;
                end
            end
            ST_SAVE: begin
                table_d[proc_q].pc = saved_pc_q;
                state_d            = ST_SELECT;
            end
            ST_RETIRE: begin
                table_d[proc_q].valid = 1'b0;
                state_d               = ST_SELECT;
            end
            ST_SELECT: begin
                halt_scan_d = 1'b0;
                pc_load_d   = 1'b1;
                if (found) begin
                    pc_next_d     = table_q[grant].pc;
                    proc_d        = grant;
                    running_d     = 1'b1;
                    switch_done_d = 1'b1;
                    state_d       = ST_LOAD;
                end else begin
                    pc_next_d = OS_IDLE_PC;
                    running_d = 1'b0;
                    state_d   = ST_HALT;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                if (valid_any) begin
                    halt_scan_d = 1'b1;
                    state_d     = ST_SELECT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Create is judged after any retire above, so retiring and recreating
        // the same slot in one cycle succeeds.
        if (create_valid) begin
            if (table_d[create_pid].valid || (create_pc <= OS_LIMIT)) begin
                create_err_d = 1'b1;
            end else begin
                table_d[create_pid].valid = 1'b1;
                table_d[create_pid].pc    = create_pc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HALT;
            for (int unsigned i = 0; i < N_PROC; i++) begin
                table_q[i] <= '0;
            end
            saved_pc_q    <= '0;
            troca_prev_q  <= 1'b0;
            halt_scan_q   <= 1'b0;
            pc_load_q     <= 1'b0;
            switch_done_q <= 1'b0;
            create_err_q  <= 1'b0;
            running_q     <= 1'b0;
            pc_next_q     <= OS_IDLE_PC;
            proc_q        <= '0;
        end else begin
            state_q       <= state_d;
            for (int unsigned i = 0; i < N_PROC; i++) begin
                table_q[i] <= table_d[i];
            end
            saved_pc_q    <= saved_pc_d;
            troca_prev_q  <= troca_prev_d;
            halt_scan_q   <= halt_scan_d;
            pc_load_q     <= pc_load_d;
            switch_done_q <= switch_done_d;
            create_err_q  <= create_err_d;
            running_q     <= running_d;
            pc_next_q     <= pc_next_d;
            proc_q        <= proc_d;
        end
    end

    assign pc_load        = pc_load_q;
    assign switch_done    = switch_done_q;
    assign create_err     = create_err_q;
    assign running        = running_q;
    assign pc_next        = pc_next_q;
    assign processo_atual = proc_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_context_switch_controller.sv
// Self-checking bench for context_switch_controller: create vectors from a table,
// expected PC loads scoreboarded and popped whenever pc_load pulses.
module tb_context_switch_controller;

    logic        clock;
    logic        reset;
    logic        troca_contexto;
    logic [31:0] pc_processo_trocado;
    logic        fim_processo;
    logic        create_valid;
    logic [2:0]  create_pid;
    logic [31:0] create_pc;
    logic        create_err;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [2:0]  processo_atual;
    logic        running;
    logic        busy;
    logic        switch_done;

    context_switch_controller #(
        .N_PROC     (8),
        .PID_W      (3),
        .OS_LIMIT   (32'd300),
        .OS_IDLE_PC (32'd0)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .troca_contexto      (troca_contexto),
        .pc_processo_trocado (pc_processo_trocado),
        .fim_processo        (fim_processo),
        .create_valid        (create_valid),
        .create_pid          (create_pid),
        .create_pc           (create_pc),
        .create_err          (create_err),
        .pc_load             (pc_load),
        .pc_next             (pc_next),
        .processo_atual      (processo_atual),
        .running             (running),
        .busy                (busy),
        .switch_done         (switch_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  pid;
        logic [31:0] pc;
        logic        exp_err;
    } cvec_t;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  pid;
        logic        run;
    } exp_t;

    cvec_t cv [6];
    exp_t  sb [$];
    int    compared;
    int    failed;
    int    n_loads;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [2:0] pid, input logic run);
        exp_t e;
        e.pc  = pc;
        e.pid = pid;
        e.run = run;
        sb.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge, pc_load pops the scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge clock);
        #1;
        if (pc_load === 1'b1) begin
            n_loads++;
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL unexpected_pc_load: got pc_next=0x%08h pid=%0d expected no load", pc_next, processo_atual);
            end else begin
                e = sb.pop_front();
                check("load_pc_next", pc_next, e.pc);
                check("load_pid", 32'(processo_atual), 32'(e.pid));
                check("load_running", 32'(running), 32'(e.run));
                if (e.run) check("load_switch_done", 32'(switch_done), 32'd1);
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic apply_creates(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            create_valid = 1'b1;
            create_pid   = cv[i].pid;
            create_pc    = cv[i].pc;
            cyc();
            create_valid = 1'b0;
            check($sformatf("create_err_vec%0d", i), 32'(create_err), 32'(cv[i].exp_err));
        end
    endtask

    // Drive a one-cycle request edge and check the 3-cycle latency to pc_load.
    task automatic switch_req(input logic [31:0] pc_in, input logic fim, input string name);
        troca_contexto      = 1'b1;
        pc_processo_trocado = pc_in;
        fim_processo        = fim;
        cyc();
        troca_contexto = 1'b0;
        fim_processo   = 1'b0;
        check({name, "_busy1"}, 32'(busy), 32'd1);
        check({name, "_noload1"}, 32'(pc_load), 32'd0);
        cyc();
        check({name, "_noload2"}, 32'(pc_load), 32'd0);
        cyc();
        check({name, "_load3"}, 32'(pc_load), 32'd1);
    endtask

    initial begin
        int loads_before;
        compared = 0;
        failed   = 0;
        n_loads  = 0;

        cv[0] = '{pid: 3'd0, pc: 32'd400,        exp_err: 1'b0};
        cv[1] = '{pid: 3'd1, pc: 32'd500,        exp_err: 1'b0};
        cv[2] = '{pid: 3'd5, pc: 32'd600,        exp_err: 1'b1};
        cv[3] = '{pid: 3'd2, pc: 32'd300,        exp_err: 1'b1};
        cv[4] = '{pid: 3'd3, pc: 32'd0,          exp_err: 1'b1};
        cv[5] = '{pid: 3'd2, pc: 32'd301,        exp_err: 1'b0};

        reset               = 1'b1;
        troca_contexto      = 1'b0;
        pc_processo_trocado = '0;
        fim_processo        = 1'b0;
        create_valid        = 1'b0;
        create_pid          = '0;
        create_pc           = '0;
        cyc();
        cyc();
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_pid", 32'(processo_atual), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_switch_done", 32'(switch_done), 32'd0);
        check("rst_create_err", 32'(create_err), 32'd0);
        reset = 1'b0;
        cyc();
        check("halt_no_valid_idle", 32'(busy), 32'd0);

        // Leave HALT once slots are created; scan starts at slot 0.
        push(32'd400, 3'd0, 1'b1);
        apply_creates(0, 1);
        drain("first_load", 10);
        cyc();

        // pid 0 -> pid 1, saving 410.
        push(32'd500, 3'd1, 1'b1);
        switch_req(32'd410, 1'b0, "sw01");
        drain("sw01_done", 5);
        cyc();

        // Level held for 10 cycles: exactly one switch, back to saved 410.
        loads_before = n_loads;
        push(32'd410, 3'd0, 1'b1);
        troca_contexto      = 1'b1;
        pc_processo_trocado = 32'd510;
        repeat (10) cyc();
        troca_contexto = 1'b0;
        repeat (5) cyc();
        check("held_one_switch", 32'(n_loads - loads_before), 32'd1);
        drain("held_done", 2);

        // Back to pid 1 (pid 0 saves 410), then fim and req together.
        push(32'd510, 3'd1, 1'b1);
        switch_req(32'd410, 1'b0, "sw10");
        drain("sw10_done", 5);
        cyc();
        push(32'd410, 3'd0, 1'b1);
        switch_req(32'd999, 1'b1, "fim_req");
        drain("fim_req_done", 5);
        cyc();

        // Last valid process retires: park at the idle PC.
        push(32'd0, 3'd0, 1'b0);
        fim_processo = 1'b1;
        cyc();
        fim_processo = 1'b0;
        cyc();
        cyc();
        check("halt_load", 32'(pc_load), 32'd1);
        drain("halt_done", 2);
        cyc();
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_running", 32'(running), 32'd0);
        repeat (3) cyc();
        check("halt_stays", 32'(busy), 32'd0);

        push(32'd301, 3'd5, 1'b1);
        create_valid = 1'b1;
        create_pid   = 3'd5;
        create_pc    = 32'd301;
        cyc();
        create_valid = 1'b0;
        check("create5_err", 32'(create_err), 32'd0);
        drain("create5_load", 10);
        cyc();

        // Rejections leave the table alone; slot 2 then accepted at 301.
        apply_creates(2, 5);
        cyc();
        check("err_single_pulse", 32'(create_err), 32'd0);

        // pid 5 -> pid 2 (scan 6,7,0,1,2).
        push(32'd301, 3'd2, 1'b1);
        switch_req(32'd777, 1'b0, "sw52");
        drain("sw52_done", 5);
        cyc();

        // Retire pid 2 and recreate it in the RETIRE cycle.
        push(32'd777, 3'd5, 1'b1);
        fim_processo = 1'b1;
        cyc();
        fim_processo = 1'b0;
        create_valid = 1'b1;
        create_pid   = 3'd2;
        create_pc    = 32'd900;
        cyc();
        create_valid = 1'b0;
        check("retire_create_err", 32'(create_err), 32'd0);
        cyc();
        check("retire_load3", 32'(pc_load), 32'd1);
        drain("retire_done", 2);
        cyc();
        push(32'd900, 3'd2, 1'b1);
        switch_req(32'd780, 1'b0, "sw52b");
        drain("sw52b_done", 5);
        cyc();

        // Asynchronous reset in the middle of SAVE.
        troca_contexto      = 1'b1;
        pc_processo_trocado = 32'd1234;
        cyc();
        troca_contexto = 1'b0;
        check("mid_save_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc_next", pc_next, 32'd0);
        check("async_rst_pid", 32'(processo_atual), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pc_load", 32'(pc_load), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) cyc();
        push(32'd301, 3'd5, 1'b1);
        create_valid = 1'b1;
        create_pid   = 3'd5;
        create_pc    = 32'd301;
        cyc();
        create_valid = 1'b0;
        check("post_rst_create_err", 32'(create_err), 32'd0);
        drain("post_rst_load", 10);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
